// File: rtl/data_mem_stage.sv
// Memory-stage data memory: byte/half/word loads and stores with misalignment detection,
// sticky error status, and optional load/store counters enabled by `define DMEM_STATS_EN.
module data_mem_stage #(
    parameter int ADDR_W = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        ErrClr,
    output logic [31:0] RDM,
    output logic        MisalignM,
    output logic        ErrSticky,
    output logic [31:0] ErrAddr,
    output logic [15:0] LoadCnt,
    output logic [15:0] StoreCnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] idx_s;
    logic [1:0]        lane_s;
    logic [31:0]       word_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic              illegal_s;
    logic              misal_s;
    logic              bad_s;
    logic              misalign_s;
    logic [3:0]        we_s;
    logic [31:0]       wdata_s;
    logic              err_sticky_q, err_sticky_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic              unused_addr_s;

    assign idx_s         = ALUResultM[ADDR_W+1:2];
    assign lane_s        = ALUResultM[1:0];
    assign unused_addr_s = ^ALUResultM[31:ADDR_W+2];

    // Access classification and load-data extraction.
    always_comb begin
        word_s    = mem_q[idx_s];
        byte_s    = 8'h00;
        half_s    = lane_s[1] ? word_s[31:16] : word_s[15:0];
        illegal_s = 1'b0;
        misal_s   = 1'b0;
        RDM       = 32'h0;
        case (lane_s)
            2'd0:    byte_s = word_s[7:0];
            2'd1:    byte_s = word_s[15:8];
            2'd2:    byte_s = word_s[23:16];
            2'd3:    byte_s = word_s[31:24];
            default: byte_s = 8'h00;
        endcase
        case (Funct3M)
            3'b001, 3'b101: misal_s = lane_s[0];
            3'b010:         misal_s = (lane_s != 2'b00);
            default:        misal_s = 1'b0;
        endcase
        // Unsigned stores do not exist, so BU/HU encodings are illegal on the write side.
        case (Funct3M)
            3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
            3'b100, 3'b101:         illegal_s = MemWriteM;
            default:                illegal_s = 1'b0;
        endcase
        bad_s      = misal_s | illegal_s;
        misalign_s = (MemReadM | MemWriteM) & bad_s;
        if (MemReadM && !bad_s) begin
            case (Funct3M)
                3'b000:  RDM = {{24{byte_s[7]}}, byte_s};
                3'b001:  RDM = {{16{half_s[15]}}, half_s};
                3'b010:  RDM = word_s;
                3'b100:  RDM = {24'h0, byte_s};
                3'b101:  RDM = {16'h0, half_s};
                default: RDM = 32'h0;
            endcase
        end else begin
            RDM = 32'h0;
        end
    end

    assign MisalignM = misalign_s;

    // Byte enables and lane-replicated store data.
    always_comb begin
        we_s    = 4'b0000;
        wdata_s = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                we_s    = 4'b0001 << lane_s;
                wdata_s = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                we_s    = lane_s[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{WriteDataM[15:0]}};
            end
            2'b10:   we_s = 4'b1111;
            default: we_s = 4'b0000;
        endcase
        if (!MemWriteM || bad_s) begin
            we_s = 4'b0000;
        end else begin
            we_s = we_s;
        end
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (we_s[i]) begin
                mem_q[idx_s][i*8 +: 8] <= wdata_s[i*8 +: 8];
            end
        end
    end

    // A new error in the clear cycle wins over the clear.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        if (misalign_s && (!err_sticky_q || ErrClr)) begin
            err_sticky_d = 1'b1;
            err_addr_d   = ALUResultM;
        end else if (ErrClr && !misalign_s) begin
            err_sticky_d = 1'b0;
            err_addr_d   = 32'h0;
        end else begin
            err_sticky_d = err_sticky_q;
            err_addr_d   = err_addr_q;
        end
    end

    // Error status registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= 32'h0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign ErrSticky = err_sticky_q;
    assign ErrAddr   = err_addr_q;

`ifdef DMEM_STATS_EN
    logic [15:0] load_cnt_q, load_cnt_d;
    logic [15:0] store_cnt_q, store_cnt_d;

    // Saturating counters of good accesses.
    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        if (MemReadM && !misalign_s && (load_cnt_q != 16'hFFFF)) begin
            load_cnt_d = load_cnt_q + 16'd1;
        end else begin
            load_cnt_d = load_cnt_q;
        end
        if (MemWriteM && !misalign_s && (store_cnt_q != 16'hFFFF)) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end else begin
            store_cnt_d = store_cnt_q;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            load_cnt_q  <= 16'h0;
            store_cnt_q <= 16'h0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign LoadCnt  = load_cnt_q;
    assign StoreCnt = store_cnt_q;
`else
    assign LoadCnt  = 16'h0;
    assign StoreCnt = 16'h0;
`endif

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: directed scenarios plus randomized traffic
// checked against a byte-array reference model.
module tb_data_mem_stage;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        MemReadM = 1'b0;
    logic [2:0]  Funct3M = 3'b000;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic        ErrClr = 1'b0;
    logic [31:0] RDM;
    logic        MisalignM;
    logic        ErrSticky;
    logic [31:0] ErrAddr;
    logic [15:0] LoadCnt;
    logic [15:0] StoreCnt;

    int n_checks = 0;
    int n_pass = 0;

    logic [7:0]  mem_m [4096];
    logic        exp_sticky = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    int          exp_ld = 0;
    int          exp_st = 0;

    data_mem_stage #(.ADDR_W(10)) dut (
        .CLK(CLK), .RST(RST), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ErrClr(ErrClr), .RDM(RDM), .MisalignM(MisalignM), .ErrSticky(ErrSticky),
        .ErrAddr(ErrAddr), .LoadCnt(LoadCnt), .StoreCnt(StoreCnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic model_bad(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        logic ill;
        logic mis;
        ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (wr && (f3 == 3'd4 || f3 == 3'd5));
        mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
        return ill || mis;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int p;
        int b;
        int h;
        p = int'(a[11:0]);
        b = int'(mem_m[p]);
        case (f3)
            3'd0: return (b > 127) ? 32'(b - 256) : 32'(b);
            3'd4: return 32'(b);
            3'd1, 3'd5: begin
                h = b + 256 * int'(mem_m[p+1]);
                if (f3 == 3'd1 && h > 32767) return 32'(h - 65536);
                return 32'(h);
            end
            3'd2: return {mem_m[p+3], mem_m[p+2], mem_m[p+1], mem_m[p]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_rdm();
        if (!MemReadM || model_bad(MemWriteM, Funct3M, ALUResultM)) return 32'h0;
        return model_load(Funct3M, ALUResultM);
    endfunction

    function automatic logic exp_mis();
        return (MemReadM | MemWriteM) & model_bad(MemWriteM, Funct3M, ALUResultM);
    endfunction

    task automatic apply(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic clr);
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        ErrClr     = clr;
        #1;
    endtask

    // Advance one clock edge, updating the reference model from the inputs presented.
    task automatic step();
        logic bad;
        logic mis;
        int   n;
        bad = model_bad(MemWriteM, Funct3M, ALUResultM);
        mis = (MemReadM | MemWriteM) & bad;
        if (mis && (!exp_sticky || ErrClr)) begin
            exp_sticky = 1'b1;
            exp_addr   = ALUResultM;
        end else if (ErrClr && !mis) begin
            exp_sticky = 1'b0;
            exp_addr   = 32'h0;
        end
        if (MemWriteM && !bad) begin
            n = (Funct3M == 3'd0) ? 1 : (Funct3M == 3'd1) ? 2 : 4;
            for (int i = 0; i < n; i++) mem_m[int'(ALUResultM[11:0]) + i] = 8'(WriteDataM >> (8 * i));
            if (exp_st < 65535) exp_st++;
        end
        if (MemReadM && !mis && exp_ld < 65535) exp_ld++;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (ErrSticky !== 1'b0) $display("FAIL reset_sticky: got %b expected 0", ErrSticky); else n_pass++;
        n_checks++; if (ErrAddr !== 32'h0) $display("FAIL reset_addr: got %h expected 0", ErrAddr); else n_pass++;
        n_checks++; if (LoadCnt !== 16'h0 || StoreCnt !== 16'h0) $display("FAIL reset_cnt: got %h/%h expected 0/0", LoadCnt, StoreCnt); else n_pass++;
        n_checks++; if (RDM !== 32'h0) $display("FAIL reset_rdm: got %h expected 0", RDM); else n_pass++;
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_word();
        apply(1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 1'b0); step();
        apply(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
        n_checks++; if (RDM !== 32'hDEADBEEF) $display("FAIL lw: got %h expected deadbeef", RDM); else n_pass++;
        apply(1'b1, 1'b0, 3'b000, 32'h43, 32'h0, 1'b0);
        n_checks++; if (RDM !== 32'hFFFFFFDE) $display("FAIL lb: got %h expected ffffffde", RDM); else n_pass++;
        apply(1'b1, 1'b0, 3'b100, 32'h43, 32'h0, 1'b0);
        n_checks++; if (RDM !== 32'h000000DE) $display("FAIL lbu: got %h expected 000000de", RDM); else n_pass++;
        apply(1'b1, 1'b0, 3'b001, 32'h42, 32'h0, 1'b0);
        n_checks++; if (RDM !== 32'hFFFFDEAD) $display("FAIL lh: got %h expected ffffdead", RDM); else n_pass++;
        apply(1'b1, 1'b0, 3'b101, 32'h40, 32'h0, 1'b0);
        n_checks++; if (RDM !== 32'h0000BEEF) $display("FAIL lhu: got %h expected 0000beef", RDM); else n_pass++;
        step();
    endtask

    task automatic test_merge();
        apply(1'b0, 1'b1, 3'b000, 32'h41, 32'hAAAAAA12, 1'b0); step();
        apply(1'b0, 1'b1, 3'b001, 32'h42, 32'hBBBB5678, 1'b0); step();
        apply(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
        n_checks++; if (RDM !== 32'h567812EF) $display("FAIL merge: got %h expected 567812ef", RDM); else n_pass++;
        // Simultaneous store and load returns pre-store contents.
        apply(1'b1, 1'b1, 3'b010, 32'h40, 32'h01020304, 1'b0);
        n_checks++; if (RDM !== 32'h567812EF) $display("FAIL rw_same: got %h expected 567812ef", RDM); else n_pass++;
        step();
        apply(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
        n_checks++; if (RDM !== 32'h01020304) $display("FAIL rw_after: got %h expected 01020304", RDM); else n_pass++;
        step();
    endtask

    task automatic test_misalign();
        apply(1'b0, 1'b1, 3'b010, 32'h44, 32'hCAFEF00D, 1'b0); step();
        apply(1'b0, 1'b1, 3'b010, 32'h46, 32'h11111111, 1'b0);
        n_checks++; if (MisalignM !== 1'b1) $display("FAIL mis_sw: got %b expected 1", MisalignM); else n_pass++;
        step();
        n_checks++; if (ErrSticky !== 1'b1 || ErrAddr !== 32'h46) $display("FAIL mis_status: got %b/%h expected 1/00000046", ErrSticky, ErrAddr); else n_pass++;
        apply(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 1'b0);
        n_checks++; if (RDM !== 32'hCAFEF00D) $display("FAIL mis_unchanged: got %h expected cafef00d", RDM); else n_pass++;
        apply(1'b1, 1'b0, 3'b001, 32'h45, 32'h0, 1'b0);
        n_checks++; if (RDM !== 32'h0 || MisalignM !== 1'b1) $display("FAIL mis_lh: got %h/%b expected 0/1", RDM, MisalignM); else n_pass++;
        step();
        n_checks++; if (ErrAddr !== 32'h46) $display("FAIL mis_first: got %h expected 00000046", ErrAddr); else n_pass++;
        apply(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1); step();
        n_checks++; if (ErrSticky !== 1'b0 || ErrAddr !== 32'h0) $display("FAIL mis_clr: got %b/%h expected 0/0", ErrSticky, ErrAddr); else n_pass++;
    endtask

    task automatic test_collision();
        apply(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 1'b1); step();
        n_checks++; if (ErrSticky !== 1'b1 || ErrAddr !== 32'h2) $display("FAIL clr_collide: got %b/%h expected 1/00000002", ErrSticky, ErrAddr); else n_pass++;
        apply(1'b1, 1'b0, 3'b011, 32'h40, 32'h0, 1'b0);
        n_checks++; if (MisalignM !== 1'b1 || RDM !== 32'h0) $display("FAIL illegal_ld: got %b/%h expected 1/0", MisalignM, RDM); else n_pass++;
        apply(1'b0, 1'b0, 3'b011, 32'h41, 32'h0, 1'b0);
        n_checks++; if (MisalignM !== 1'b0) $display("FAIL idle_mis: got %b expected 0", MisalignM); else n_pass++;
        apply(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1); step();
    endtask

    task automatic test_async_reset();
        apply(1'b1, 1'b0, 3'b010, 32'h1, 32'h0, 1'b0); step();
        n_checks++; if (ErrSticky !== 1'b1) $display("FAIL ar_set: got %b expected 1", ErrSticky); else n_pass++;
        apply(1'b0, 1'b1, 3'b010, 32'h80, 32'h12345678, 1'b0);
        RST = 1'b0;
        #1;
        n_checks++; if (ErrSticky !== 1'b0 || ErrAddr !== 32'h0) $display("FAIL ar_clear: got %b/%h expected 0/0", ErrSticky, ErrAddr); else n_pass++;
        MemWriteM = 1'b0;
        RST = 1'b1;
        exp_sticky = 1'b0;
        exp_addr = 32'h0;
        exp_ld = 0;
        exp_st = 0;
        step();
    endtask

    task automatic test_random();
        logic [2:0] f3_tab [8];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
        for (int i = 0; i < 1024; i++) begin
            apply(1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom, 1'b0);
            step();
        end
        for (int i = 0; i < 600; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)],
                  $urandom, $urandom, ($urandom_range(0, 7) == 0));
            n_checks++; if (RDM !== exp_rdm()) $display("FAIL rnd_rdm: addr %h f3 %0d got %h expected %h", ALUResultM, Funct3M, RDM, exp_rdm()); else n_pass++;
            n_checks++; if (MisalignM !== exp_mis()) $display("FAIL rnd_mis: addr %h f3 %0d got %b expected %b", ALUResultM, Funct3M, MisalignM, exp_mis()); else n_pass++;
            step();
            n_checks++; if (ErrSticky !== exp_sticky || ErrAddr !== exp_addr) $display("FAIL rnd_status: got %b/%h expected %b/%h", ErrSticky, ErrAddr, exp_sticky, exp_addr); else n_pass++;
`ifdef DMEM_STATS_EN
            n_checks++; if (LoadCnt !== 16'(exp_ld) || StoreCnt !== 16'(exp_st)) $display("FAIL rnd_cnt: got %h/%h expected %h/%h", LoadCnt, StoreCnt, 16'(exp_ld), 16'(exp_st)); else n_pass++;
`else
            n_checks++; if (LoadCnt !== 16'h0 || StoreCnt !== 16'h0) $display("FAIL rnd_cnt_off: got %h/%h expected 0/0", LoadCnt, StoreCnt); else n_pass++;
`endif
        end
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        RST = 1'b0;
        #1;
        RST = 1'b1;
        exp_ld = 0;
        exp_st = 0;
        exp_sticky = 1'b0;
        exp_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0); step();
        end
        apply(1'b0, 1'b1, 3'b000, 32'h41, 32'h5A, 1'b0); step();
        apply(1'b0, 1'b1, 3'b010, 32'h48, 32'h77, 1'b0); step();
        apply(1'b0, 1'b1, 3'b010, 32'h49, 32'h88, 1'b0); step();
        n_checks++; if (LoadCnt !== 16'd3 || StoreCnt !== 16'd2) $display("FAIL stats_cnt: got %0d/%0d expected 3/2", LoadCnt, StoreCnt); else n_pass++;
        for (int i = 0; i < 65537; i++) begin
            apply(1'b1, 1'b0, 3'b100, 32'(i), 32'h0, 1'b0); step();
        end
        n_checks++; if (LoadCnt !== 16'hFFFF) $display("FAIL stats_sat: got %h expected ffff", LoadCnt); else n_pass++;
        n_checks++; if (StoreCnt !== 16'd2) $display("FAIL stats_st_hold: got %0d expected 2", StoreCnt); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_word();
        test_merge();
        test_misalign();
        test_collision();
        test_async_reset();
        test_random();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
